// File: rtl/ex_pkg.sv
// Shared decode constants and enums for the execute stage.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: opcode/funct codes, ALU operation enum, mul/div engine state enum.
package ex_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASS_HI, ALU_PASS_LO
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE, MD_MUL, MD_DIV, MD_FIX
  } md_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
// Latency: n/a (wires only).
// Backpressure: stallOut tells the ID/EX side to hold its instruction.
// Modports: master = ID/EX driver and EX/MEM consumer, slave = ex_stage.
interface ex_stage_if;
  logic        validIn;
  logic [31:0] readData1In;
  logic [31:0] readData2In;
  logic [31:0] signExtendIn;
  logic [31:0] instrIn;
  logic        regWriteIn;
  logic        memReadIn;
  logic        memWriteIn;

  logic        validOut;
  logic [31:0] aluResultOut;
  logic [31:0] storeDataOut;
  logic [4:0]  destRegOut;
  logic        regWriteOut;
  logic        memReadOut;
  logic        memWriteOut;
  logic        overflowOut;
  logic        stallOut;
  logic        mdBusyOut;

  modport master (
    output validIn, readData1In, readData2In, signExtendIn, instrIn,
           regWriteIn, memReadIn, memWriteIn,
    input  validOut, aluResultOut, storeDataOut, destRegOut, regWriteOut,
           memReadOut, memWriteOut, overflowOut, stallOut, mdBusyOut
  );

  modport slave (
    input  validIn, readData1In, readData2In, signExtendIn, instrIn,
           regWriteIn, memReadIn, memWriteIn,
    output validOut, aluResultOut, storeDataOut, destRegOut, regWriteOut,
           memReadOut, memWriteOut, overflowOut, stallOut, mdBusyOut
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative shift-add multiplier / restoring divider holding HI and LO.
// Latency: start sampled at edge N, MD_CYCLES iterations, one fix-up cycle; HI/LO valid for readers sampled at N+MD_CYCLES+2.
// Backpressure: none internally; busy/fixing let the caller stall dependent instructions.
// Ports: clk, rst_n (sync), start/is_div/is_signed/op_a/op_b issue, busy/fixing status, hi/lo results.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             fixing,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MD_CYCLES);

  md_state_e        state;
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic             neg_res;   // product/quotient must be negated in FIX
  logic             neg_rem;   // remainder follows the dividend sign
  logic             div0;
  // acc: product high half / partial remainder; sh: multiplier / quotient
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] opnd;      // multiplicand / divisor magnitude

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [2*WIDTH-1:0] prod;
  logic             unused_bits;

  // Engine works on magnitudes; signs are reapplied in FIX.
  assign a_neg = is_signed & op_a[WIDTH-1];
  assign b_neg = is_signed & op_b[WIDTH-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  assign mul_sum = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);

  // Extra guard bit on diff gives a clean borrow for the restore decision.
  assign trial = {acc, sh[WIDTH-1]};
  assign diff  = {1'b0, trial} - {2'b00, opnd};
  assign ge    = ~diff[WIDTH+1];
  assign prod  = {acc, sh};
  assign unused_bits = diff[WIDTH];

  assign busy   = (state == MD_MUL) || (state == MD_DIV);
  assign fixing = (state == MD_FIX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      acc     <= '0;
      sh      <= '0;
      opnd    <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            acc     <= '0;
            sh      <= a_mag;
            opnd    <= b_mag;
            op_div  <= is_div;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= (op_b == '0);
            cnt     <= '0;
            state   <= is_div ? MD_DIV : MD_MUL;
          end
        end
        MD_MUL: begin
          acc <= mul_sum[WIDTH:1];
          sh  <= {mul_sum[0], sh[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(MD_CYCLES - 1)) state <= MD_FIX;
        end
        MD_DIV: begin
          acc <= ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          sh  <= {sh[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(MD_CYCLES - 1)) state <= MD_FIX;
        end
        MD_FIX: begin
          if (op_div) begin
            // Divide by zero: all-ones quotient; remainder naturally ends as the dividend.
            lo <= div0 ? '1 : (neg_res ? -sh : sh);
            hi <= neg_rem ? -acc : acc;
          end else begin
            {hi, lo} <= neg_res ? -prod : prod;
          end
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: decode, single-cycle ALU, EX/MEM register, iterative mul/div with HI/LO.
// Latency: 1 cycle ID/EX -> EX/MEM; mul/div results readable 34 cycles after issue.
// Backpressure: stallOut (combinational) holds ID/EX while a HI/LO-dependent op meets a busy engine; a bubble is inserted.
// Ports: clk, rst_n (sync active-low), bus (ex_stage_if.slave: ID/EX inputs, EX/MEM outputs, stall/busy).
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  ex_stage_if.slave bus
);

  logic [5:0]       opcode, funct;
  logic [4:0]       shamt, dest;
  logic [15:0]      imm16;
  logic [WIDTH-1:0] rs, rt, b_op;

  alu_op_e          alu_op;
  logic             use_imm, zero_imm, known, ovf_chk;
  logic             md_op, md_div, md_signed, md_dep;

  logic [WIDTH-1:0] sum, dif, alu_res;
  logic             ovf_hit, stall, issue;
  logic             md_busy, md_fix;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic             unused_fields;

  assign opcode = bus.instrIn[31:26];
  assign funct  = bus.instrIn[5:0];
  assign shamt  = bus.instrIn[10:6];
  assign imm16  = bus.instrIn[15:0];
  assign rs     = bus.readData1In;
  assign rt     = bus.readData2In;
  assign dest   = (opcode == OP_RTYPE) ? bus.instrIn[15:11] : bus.instrIn[20:16];
  assign unused_fields = ^bus.instrIn[25:21];

  always_comb begin
    alu_op    = ALU_ADD;
    use_imm   = 1'b0;
    zero_imm  = 1'b0;
    known     = 1'b1;
    ovf_chk   = 1'b0;
    md_op     = 1'b0;
    md_div    = 1'b0;
    md_signed = 1'b0;
    md_dep    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   ovf_chk = 1'b1;
          F_ADDU:  alu_op = ALU_ADD;
          F_SUB:   begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
          F_SUBU:  alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_XOR:   alu_op = ALU_XOR;
          F_NOR:   alu_op = ALU_NOR;
          F_SLT:   alu_op = ALU_SLT;
          F_SLTU:  alu_op = ALU_SLTU;
          F_SLL:   alu_op = ALU_SLL;
          F_SRL:   alu_op = ALU_SRL;
          F_SRA:   alu_op = ALU_SRA;
          F_MFHI:  begin alu_op = ALU_PASS_HI; md_dep = 1'b1; end
          F_MFLO:  begin alu_op = ALU_PASS_LO; md_dep = 1'b1; end
          // Mul/div retire with a zero result; the engine owns the real work.
          F_MULT:  begin known = 1'b0; md_op = 1'b1; md_dep = 1'b1; md_signed = 1'b1; end
          F_MULTU: begin known = 1'b0; md_op = 1'b1; md_dep = 1'b1; end
          F_DIV:   begin known = 1'b0; md_op = 1'b1; md_dep = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
          F_DIVU:  begin known = 1'b0; md_op = 1'b1; md_dep = 1'b1; md_div = 1'b1; end
          default: known = 1'b0;
        endcase
      end
      OP_ADDI:      begin use_imm = 1'b1; ovf_chk = 1'b1; end
      OP_ADDIU:     use_imm = 1'b1;
      OP_SLTI:      begin use_imm = 1'b1; alu_op = ALU_SLT; end
      OP_SLTIU:     begin use_imm = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:      begin use_imm = 1'b1; zero_imm = 1'b1; alu_op = ALU_AND; end
      OP_ORI:       begin use_imm = 1'b1; zero_imm = 1'b1; alu_op = ALU_OR; end
      OP_XORI:      begin use_imm = 1'b1; zero_imm = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:       alu_op = ALU_LUI;
      OP_LW, OP_SW: use_imm = 1'b1;
      default:      known = 1'b0;
    endcase
  end

  assign b_op = !use_imm ? rt :
                zero_imm ? {{(WIDTH-16){1'b0}}, imm16} : bus.signExtendIn;
  assign sum  = rs + b_op;
  assign dif  = rs - b_op;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:     alu_res = sum;
      ALU_SUB:     alu_res = dif;
      ALU_AND:     alu_res = rs & b_op;
      ALU_OR:      alu_res = rs | b_op;
      ALU_XOR:     alu_res = rs ^ b_op;
      ALU_NOR:     alu_res = ~(rs | b_op);
      ALU_SLT:     alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(b_op))};
      ALU_SLTU:    alu_res = {{(WIDTH-1){1'b0}}, (rs < b_op)};
      ALU_SLL:     alu_res = rt << shamt;
      ALU_SRL:     alu_res = rt >> shamt;
      ALU_SRA:     alu_res = $signed(rt) >>> shamt;
      ALU_LUI:     alu_res = {imm16, {(WIDTH-16){1'b0}}};
      ALU_PASS_HI: alu_res = md_hi;
      ALU_PASS_LO: alu_res = md_lo;
      default:     alu_res = '0;
    endcase
  end

  // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
  always_comb begin
    ovf_hit = 1'b0;
    if (ovf_chk) begin
      if (alu_op == ALU_SUB)
        ovf_hit = (rs[WIDTH-1] != b_op[WIDTH-1]) && (dif[WIDTH-1] != rs[WIDTH-1]);
      else
        ovf_hit = (rs[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
    end
  end

  // FIX counts as busy so a reader never samples HI/LO in the write cycle.
  assign stall = bus.validIn & (md_busy | md_fix) & md_dep;
  assign issue = bus.validIn & ~stall;

  assign bus.stallOut  = stall;
  assign bus.mdBusyOut = md_busy;

  ex_muldiv #(
    .WIDTH     (WIDTH),
    .MD_CYCLES (MD_CYCLES)
  ) u_md (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (issue & md_op),
    .is_div    (md_div),
    .is_signed (md_signed),
    .op_a      (rs),
    .op_b      (rt),
    .busy      (md_busy),
    .fixing    (md_fix),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !issue) begin
      bus.validOut     <= 1'b0;
      bus.aluResultOut <= '0;
      bus.storeDataOut <= '0;
      bus.destRegOut   <= '0;
      bus.regWriteOut  <= 1'b0;
      bus.memReadOut   <= 1'b0;
      bus.memWriteOut  <= 1'b0;
      bus.overflowOut  <= 1'b0;
    end else begin
      bus.validOut     <= 1'b1;
      bus.aluResultOut <= known ? alu_res : '0;
      bus.storeDataOut <= rt;
      bus.destRegOut   <= dest;
      bus.regWriteOut  <= bus.regWriteIn & ~ovf_hit & ~md_op;
      bus.memReadOut   <= bus.memReadIn;
      bus.memWriteOut  <= bus.memWriteIn;
      bus.overflowOut  <= ovf_hit;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of single-cycle ALU vectors plus mul/div sequences.
// Latency: results checked 1 ns after the capturing edge.
// Backpressure: stall counts and bubbles checked for HI/LO-dependent instructions.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] instr, rs, rt;
    logic        v, rw, mr, mw;
    logic [31:0] res, store;
    logic [4:0]  dest;
    logic        ev, erw, emr, emw, eo;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rtype(logic [4:0] rd, logic [4:0] sa, logic [5:0] fn);
    return {6'h00, 5'd0, 5'd0, rd, sa, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rt_f, logic [15:0] imm);
    return {op, 5'd0, rt_f, imm};
  endfunction

  function automatic vec_t mk(string n, logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                              logic v, logic rw, logic mr, logic mw,
                              logic [31:0] res, logic [4:0] d,
                              logic ev, logic erw, logic emr, logic emw, logic eo);
    vec_t t;
    t.name = n; t.instr = ins; t.rs = a; t.rt = b;
    t.v = v; t.rw = rw; t.mr = mr; t.mw = mw;
    t.res = res; t.dest = d; t.store = ev ? b : 32'h0;
    t.ev = ev; t.erw = erw; t.emr = emr; t.emw = emw; t.eo = eo;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic rw, input logic mr, input logic mw);
    bus.validIn      = v;
    bus.instrIn      = ins;
    bus.readData1In  = a;
    bus.readData2In  = b;
    bus.signExtendIn = {{16{ins[15]}}, ins[15:0]};
    bus.regWriteIn   = rw;
    bus.memReadIn    = mr;
    bus.memWriteIn   = mw;
  endtask

  // Present a mfhi/mflo (or any dependent op) and count stall cycles until it retires.
  task automatic read_md(input string name, input logic [5:0] fn, input logic [31:0] exp,
                         input int exp_stalls);
    int stalls;
    stalls = 0;
    drive(1'b1, rtype(5'd2, 5'd0, fn), 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    while (bus.stallOut && stalls < 40) begin
      @(posedge clk); #1;
      check({name, "_bubble"}, {31'b0, bus.validOut}, 32'h0);
      stalls++;
    end
    if (stalls >= 40) begin
      check({name, "_timeout"}, 32'(stalls), 32'(exp_stalls));
    end else begin
      check({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      @(posedge clk); #1;
      check({name, "_valid"}, {31'b0, bus.validOut}, 32'h1);
      check({name, "_res"}, bus.aluResultOut, exp);
      check({name, "_regw"}, {31'b0, bus.regWriteOut}, 32'h1);
    end
  endtask

  // Issue a mul/div op and check it retires as a valid no-write instruction.
  task automatic issue_md(input string name, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b);
    drive(1'b1, rtype(5'd0, 5'd0, fn), a, b, 1'b1, 1'b0, 1'b0);
    #1;
    check({name, "_nostall"}, {31'b0, bus.stallOut}, 32'h0);
    @(posedge clk); #1;
    check({name, "_valid"}, {31'b0, bus.validOut}, 32'h1);
    check({name, "_regw"}, {31'b0, bus.regWriteOut}, 32'h0);
    check({name, "_busy"}, {31'b0, bus.mdBusyOut}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset with a live instruction presented ----
    drive(1'b1, rtype(5'd3, 5'd0, 6'h20), 32'h7FFFFFFF, 32'h1, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, bus.validOut}, 32'h0);
    check("rst_res", bus.aluResultOut, 32'h0);
    check("rst_store", bus.storeDataOut, 32'h0);
    check("rst_dest", {27'b0, bus.destRegOut}, 32'h0);
    check("rst_ctl", {29'b0, bus.regWriteOut, bus.memReadOut, bus.memWriteOut}, 32'h0);
    check("rst_ovf", {31'b0, bus.overflowOut}, 32'h0);
    check("rst_stall", {31'b0, bus.stallOut}, 32'h0);
    check("rst_busy", {31'b0, bus.mdBusyOut}, 32'h0);
    check("rst_hi", dut.u_md.hi, 32'h0);
    check("rst_lo", dut.u_md.lo, 32'h0);
    rst_n = 1'b1;

    // ---- single-cycle vectors ----
    vecs.push_back(mk("add_ovf",  rtype(5'd3, 5'd0, 6'h20), 32'h7FFFFFFF, 32'h1, 1,1,0,0, 32'h80000000, 5'd3, 1,0,0,0,1));
    vecs.push_back(mk("addu",     rtype(5'd4, 5'd0, 6'h21), 32'h7FFFFFFF, 32'h1, 1,1,0,0, 32'h80000000, 5'd4, 1,1,0,0,0));
    vecs.push_back(mk("lw",       itype(6'h23, 5'd5, 16'hFFFC), 32'h1000, 32'hAAAA5555, 1,1,1,0, 32'h00000FFC, 5'd5, 1,1,1,0,0));
    vecs.push_back(mk("sw",       itype(6'h2B, 5'd6, 16'h0008), 32'h100, 32'h12345678, 1,0,0,1, 32'h00000108, 5'd6, 1,0,0,1,0));
    vecs.push_back(mk("sub",      rtype(5'd7, 5'd0, 6'h22), 32'h5, 32'h7, 1,1,0,0, 32'hFFFFFFFE, 5'd7, 1,1,0,0,0));
    vecs.push_back(mk("sub_ovf",  rtype(5'd8, 5'd0, 6'h22), 32'h80000000, 32'h1, 1,1,0,0, 32'h7FFFFFFF, 5'd8, 1,0,0,0,1));
    vecs.push_back(mk("subu",     rtype(5'd9, 5'd0, 6'h23), 32'h80000000, 32'h1, 1,1,0,0, 32'h7FFFFFFF, 5'd9, 1,1,0,0,0));
    vecs.push_back(mk("slt",      rtype(5'd10, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'h1, 1,1,0,0, 32'h1, 5'd10, 1,1,0,0,0));
    vecs.push_back(mk("sltu",     rtype(5'd11, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'h1, 1,1,0,0, 32'h0, 5'd11, 1,1,0,0,0));
    vecs.push_back(mk("sra",      rtype(5'd12, 5'd4, 6'h03), 32'h0, 32'hF0000000, 1,1,0,0, 32'hFF000000, 5'd12, 1,1,0,0,0));
    vecs.push_back(mk("srl",      rtype(5'd13, 5'd4, 6'h02), 32'h0, 32'hF0000000, 1,1,0,0, 32'h0F000000, 5'd13, 1,1,0,0,0));
    vecs.push_back(mk("sll",      rtype(5'd14, 5'd31, 6'h00), 32'h0, 32'h1, 1,1,0,0, 32'h80000000, 5'd14, 1,1,0,0,0));
    vecs.push_back(mk("and",      rtype(5'd15, 5'd0, 6'h24), 32'hF0F0F0F0, 32'hFF00FF00, 1,1,0,0, 32'hF000F000, 5'd15, 1,1,0,0,0));
    vecs.push_back(mk("nor",      rtype(5'd16, 5'd0, 6'h27), 32'h0, 32'h0, 1,1,0,0, 32'hFFFFFFFF, 5'd16, 1,1,0,0,0));
    vecs.push_back(mk("xor",      rtype(5'd17, 5'd0, 6'h26), 32'hA5A5A5A5, 32'hFFFF0000, 1,1,0,0, 32'h5A5AA5A5, 5'd17, 1,1,0,0,0));
    vecs.push_back(mk("or",       rtype(5'd18, 5'd0, 6'h25), 32'h1, 32'h2, 1,1,0,0, 32'h3, 5'd18, 1,1,0,0,0));
    vecs.push_back(mk("lui",      itype(6'h0F, 5'd18, 16'h1234), 32'h55555555, 32'h0, 1,1,0,0, 32'h12340000, 5'd18, 1,1,0,0,0));
    vecs.push_back(mk("ori",      itype(6'h0D, 5'd19, 16'h8001), 32'hF0F00000, 32'h0, 1,1,0,0, 32'hF0F08001, 5'd19, 1,1,0,0,0));
    vecs.push_back(mk("andi",     itype(6'h0C, 5'd20, 16'hFFFF), 32'h12345678, 32'h0, 1,1,0,0, 32'h00005678, 5'd20, 1,1,0,0,0));
    vecs.push_back(mk("xori",     itype(6'h0E, 5'd21, 16'h00FF), 32'h0000FFFF, 32'h0, 1,1,0,0, 32'h0000FF00, 5'd21, 1,1,0,0,0));
    vecs.push_back(mk("sltiu",    itype(6'h0B, 5'd22, 16'hFFFF), 32'h5, 32'h0, 1,1,0,0, 32'h1, 5'd22, 1,1,0,0,0));
    vecs.push_back(mk("slti",     itype(6'h0A, 5'd23, 16'hFFFF), 32'h5, 32'h0, 1,1,0,0, 32'h0, 5'd23, 1,1,0,0,0));
    vecs.push_back(mk("addi_ovf", itype(6'h08, 5'd24, 16'h0001), 32'h7FFFFFFF, 32'h0, 1,1,0,0, 32'h80000000, 5'd24, 1,0,0,0,1));
    vecs.push_back(mk("addiu",    itype(6'h09, 5'd25, 16'hFFFF), 32'h0, 32'h0, 1,1,0,0, 32'hFFFFFFFF, 5'd25, 1,1,0,0,0));
    vecs.push_back(mk("bad_op",   itype(6'h3F, 5'd26, 16'h0000), 32'h1234, 32'h9, 1,1,0,1, 32'h0, 5'd26, 1,1,0,1,0));
    vecs.push_back(mk("bad_fn",   rtype(5'd27, 5'd0, 6'h3F), 32'h1234, 32'h9, 1,1,0,0, 32'h0, 5'd27, 1,1,0,0,0));
    vecs.push_back(mk("bubble",   rtype(5'd3, 5'd0, 6'h20), 32'h1, 32'h2, 0,1,1,1, 32'h0, 5'd0, 0,0,0,0,0));
    vecs.push_back(mk("mfhi0",    rtype(5'd28, 5'd0, 6'h10), 32'h0, 32'h0, 1,1,0,0, 32'h0, 5'd28, 1,1,0,0,0));
    vecs.push_back(mk("mflo0",    rtype(5'd29, 5'd0, 6'h12), 32'h0, 32'h0, 1,1,0,0, 32'h0, 5'd29, 1,1,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].instr, vecs[i].rs, vecs[i].rt, vecs[i].rw, vecs[i].mr, vecs[i].mw);
      #1;
      check({vecs[i].name, "_stall"}, {31'b0, bus.stallOut}, 32'h0);
      @(posedge clk); #1;
      check({vecs[i].name, "_valid"}, {31'b0, bus.validOut}, {31'b0, vecs[i].ev});
      check({vecs[i].name, "_res"}, bus.aluResultOut, vecs[i].res);
      check({vecs[i].name, "_store"}, bus.storeDataOut, vecs[i].store);
      check({vecs[i].name, "_dest"}, {27'b0, bus.destRegOut}, {27'b0, vecs[i].dest});
      check({vecs[i].name, "_ctl"}, {29'b0, bus.regWriteOut, bus.memReadOut, bus.memWriteOut},
            {29'b0, vecs[i].erw, vecs[i].emr, vecs[i].emw});
      check({vecs[i].name, "_ovf"}, {31'b0, bus.overflowOut}, {31'b0, vecs[i].eo});
    end

    // ---- signed multiply, dependent mflo right behind it ----
    issue_md("mult", 6'h18, 32'hFFFFFFFE, 32'h3);
    read_md("mult_lo", 6'h12, 32'hFFFFFFFA, 33);
    read_md("mult_hi", 6'h10, 32'hFFFFFFFF, 0);

    // ---- divu by zero with an independent op during the iteration ----
    issue_md("divu0", 6'h1B, 32'h7, 32'h0);
    drive(1'b1, rtype(5'd5, 5'd0, 6'h25), 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    #1;
    check("indep_stall", {31'b0, bus.stallOut}, 32'h0);
    @(posedge clk); #1;
    check("indep_valid", {31'b0, bus.validOut}, 32'h1);
    check("indep_res", bus.aluResultOut, 32'h3);
    check("indep_busy", {31'b0, bus.mdBusyOut}, 32'h1);
    read_md("divu0_lo", 6'h12, 32'hFFFFFFFF, 32);
    read_md("divu0_hi", 6'h10, 32'h7, 0);

    // ---- signed divide corners ----
    issue_md("div_min", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
    read_md("div_min_lo", 6'h12, 32'h80000000, 33);
    read_md("div_min_hi", 6'h10, 32'h0, 0);
    issue_md("div_neg", 6'h1A, 32'hFFFFFFF9, 32'h2);
    read_md("div_neg_lo", 6'h12, 32'hFFFFFFFD, 33);
    read_md("div_neg_hi", 6'h10, 32'hFFFFFFFF, 0);
    issue_md("div_z", 6'h1A, 32'hFFFFFFF9, 32'h0);
    read_md("div_z_lo", 6'h12, 32'hFFFFFFFF, 33);
    read_md("div_z_hi", 6'h10, 32'hFFFFFFF9, 0);
    issue_md("multu", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    read_md("multu_hi", 6'h10, 32'hFFFFFFFE, 33);
    read_md("multu_lo", 6'h12, 32'h00000001, 0);

    // ---- reset in the middle of a divide ----
    issue_md("div_rst", 6'h1A, 32'h100, 32'h7);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("div_rst_midbusy", {31'b0, bus.mdBusyOut}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("div_rst_idle", {31'b0, bus.mdBusyOut}, 32'h0);
    check("div_rst_fix", {31'b0, dut.u_md.fixing}, 32'h0);
    read_md("div_rst_hi", 6'h10, 32'h0, 0);
    read_md("div_rst_lo", 6'h12, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
